// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the ibus/dbus arbiter: default bus widths, FSM
// state encoding, grant identifiers and the round-robin decision helper.
// The optional watchdog (enabled with ARB_TIMEOUT_EN) sizes its counter
// with wd_width().

package bus_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IBUS = 2'd1,
        ST_DBUS = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    typedef struct packed {
        logic   valid;
        grant_t who;
    } grant_dec_t;

    // Round-robin pick: a lone requester wins outright; on a tie the master
    // that did not win last time is served.
    function automatic grant_dec_t arbitrate(input logic i_want, input logic d_want,
                                             input grant_t last);
        grant_dec_t dec;
        dec.valid = i_want | d_want;
        if (i_want && d_want) begin
            dec.who = (last == GNT_I) ? GNT_D : GNT_I;
        end else if (d_want) begin
            dec.who = GNT_D;
        end else begin
            dec.who = GNT_I;
        end
        return dec;
    endfunction

    // Watchdog counter width: enough bits for the limit, kept within 8..16.
    function automatic int wd_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        if (w < 8) begin
            w = 8;
        end else if (w > 16) begin
            w = 16;
        end
        return w;
    endfunction

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// Transaction watchdog for the bus arbiter, instantiated only when
// ARB_TIMEOUT_EN is defined. The counter restarts on every grant and
// advances while a bus transaction is outstanding. 'expired' is raised in
// the last bus cycle allowed, so the aborted ack lands TIMEOUT cycles after
// the cycle in which the master first requested.

module bus_arb_watchdog
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    output logic expired
);

    localparam int CW = wd_width(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT >= 2) ? TIMEOUT - 2 : 0);
    localparam logic [CW-1:0] CMAX  = '1;

    logic [CW-1:0] count;

    // Count cycles spent waiting on the slave, saturating at the top value.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (active && (count != CMAX)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = active && (count >= LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Shares one single-ported bus between the fetch path (ibus, read-only) and
// the memory-access path (dbus, read/write). Round-robin on ties, registered
// grants and bus signals, one-cycle master acks, per-stage stall requests,
// and discard of an in-flight fetch on pipeline flush.
// Optional: define ARB_TIMEOUT_EN to add a watchdog that aborts a hung
// transaction after TIMEOUT cycles and flags it on err_o.

module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                i_req_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    output logic                i_ack_o,
    output logic [DATA_W-1:0]   i_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W/8-1:0] d_sel_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_ack_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                stallreq_if_o,
    output logic                stallreq_mem_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic                bus_ack_i,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    output logic                err_o
);

    arb_state_t        state;
    grant_t            last_grant;
    logic              discard;
    grant_dec_t        decision;
    logic              start;
    logic              timeout_hit;
    logic              done;
    logic              aborted;
    logic [DATA_W-1:0] resp_data;

    // A master whose ack is showing this cycle still holds its request; the
    // stall terms double as "really pending" so that stale request is not
    // granted a second time.
    assign stallreq_if_o  = i_req_i & ~i_ack_o;
    assign stallreq_mem_o = d_req_i & ~d_ack_o;

    assign decision  = arbitrate(stallreq_if_o & ~flush_i, stallreq_mem_o, last_grant);
    assign start     = (state == ST_IDLE) && decision.valid;
    assign done      = bus_ack_i | timeout_hit;
    assign aborted   = timeout_hit & ~bus_ack_i;
    assign resp_data = aborted ? '0 : bus_rdata_i;

`ifdef ARB_TIMEOUT_EN
    logic err_q;

    bus_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (start),
        .active  (state != ST_IDLE),
        .expired (timeout_hit)
    );

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    // Arbitration FSM: grant from IDLE, hold the bus until the slave (or the
    // watchdog) ends the transfer, then return the response to its master.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_grant  <= GNT_I;
            discard     <= 1'b0;
            i_ack_o     <= 1'b0;
            i_rdata_o   <= '0;
            d_ack_o     <= 1'b0;
            d_rdata_o   <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= '0;
            bus_wdata_o <= '0;
`ifdef ARB_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            i_ack_o <= 1'b0;
            d_ack_o <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bus_req_o  <= 1'b1;
                        last_grant <= decision.who;
                        discard    <= 1'b0;
                        if (decision.who == GNT_D) begin
                            state       <= ST_DBUS;
                            bus_we_o    <= d_we_i;
                            bus_addr_o  <= d_addr_i;
                            bus_sel_o   <= d_sel_i;
                            bus_wdata_o <= d_wdata_i;
                        end else begin
                            state       <= ST_IBUS;
                            bus_we_o    <= 1'b0;
                            bus_addr_o  <= i_addr_i;
                            bus_sel_o   <= '1;
                            bus_wdata_o <= '0;
                        end
                    end
                end
                ST_IBUS: begin
                    if (done) begin
                        state     <= ST_IDLE;
                        bus_req_o <= 1'b0;
                        discard   <= 1'b0;
                        if (!(discard || flush_i)) begin
                            i_ack_o   <= 1'b1;
                            i_rdata_o <= resp_data;
`ifdef ARB_TIMEOUT_EN
                            err_q     <= aborted;
`endif
                        end
                    end else if (flush_i) begin
                        discard <= 1'b1;
                    end
                end
                ST_DBUS: begin
                    if (done) begin
                        state     <= ST_IDLE;
                        bus_req_o <= 1'b0;
                        d_ack_o   <= 1'b1;
                        d_rdata_o <= resp_data;
`ifdef ARB_TIMEOUT_EN
                        err_q     <= aborted;
`endif
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    bus_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter. Directed scenarios push the expected
// master responses into a queue; a monitor pops and compares on every ack.
// Bus-side and stall behaviour is checked inline. Define ARB_TIMEOUT_EN to
// also exercise the watchdog (TIMEOUT=8).

module tb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush_i;
    logic            i_req_i;
    logic [AW-1:0]   i_addr_i;
    logic            i_ack_o;
    logic [DW-1:0]   i_rdata_o;
    logic            d_req_i;
    logic            d_we_i;
    logic [AW-1:0]   d_addr_i;
    logic [DW/8-1:0] d_sel_i;
    logic [DW-1:0]   d_wdata_i;
    logic            d_ack_o;
    logic [DW-1:0]   d_rdata_o;
    logic            stallreq_if_o;
    logic            stallreq_mem_o;
    logic            bus_req_o;
    logic            bus_we_o;
    logic [AW-1:0]   bus_addr_o;
    logic [DW/8-1:0] bus_sel_o;
    logic [DW-1:0]   bus_wdata_o;
    logic            bus_ack_i;
    logic [DW-1:0]   bus_rdata_i;
    logic            err_o;

    bus_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .i_req_i        (i_req_i),
        .i_addr_i       (i_addr_i),
        .i_ack_o        (i_ack_o),
        .i_rdata_o      (i_rdata_o),
        .d_req_i        (d_req_i),
        .d_we_i         (d_we_i),
        .d_addr_i       (d_addr_i),
        .d_sel_i        (d_sel_i),
        .d_wdata_i      (d_wdata_i),
        .d_ack_o        (d_ack_o),
        .d_rdata_o      (d_rdata_o),
        .stallreq_if_o  (stallreq_if_o),
        .stallreq_mem_o (stallreq_mem_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_sel_o      (bus_sel_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_ack_i      (bus_ack_i),
        .bus_rdata_i    (bus_rdata_i),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_d;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            slave_lat  = 0;
    logic          slave_en   = 1'b1;
    logic [DW-1:0] slave_data = '0;
    int            wait_cnt   = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic expectAck(input logic is_d, input logic [DW-1:0] data, input logic err);
        exp_t e;
        e.is_d  = is_d;
        e.rdata = data;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic ireq, input logic [AW-1:0] iaddr,
                                 input logic dreq, input logic dwe,
                                 input logic [AW-1:0] daddr, input logic [DW/8-1:0] dsel,
                                 input logic [DW-1:0] dwdata);
        i_req_i   = ireq;
        i_addr_i  = iaddr;
        d_req_i   = dreq;
        d_we_i    = dwe;
        d_addr_i  = daddr;
        d_sel_i   = dsel;
        d_wdata_i = dwdata;
    endtask

    // Slave model: acks after slave_lat waiting cycles of an active request.
    initial begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req_o && slave_en) begin
                if (wait_cnt >= slave_lat) begin
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = slave_data;
                    wait_cnt    = 0;
                end else begin
                    bus_ack_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus_ack_i = 1'b0;
                wait_cnt  = 0;
            end
        end
    end

    // Monitor: every master ack (or error flag) must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (i_ack_o || d_ack_o || err_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_ack: i_ack=%0b d_ack=%0b err=%0b, required no ack",
                             i_ack_o, d_ack_o, err_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("ack_master", {62'd0, i_ack_o, d_ack_o},
                                mon_e.is_d ? 64'd1 : 64'd2);
                    checkOutput("ack_rdata", mon_e.is_d ? d_rdata_o : i_rdata_o, mon_e.rdata);
                    checkOutput("ack_err", err_o, mon_e.err);
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        flush_i = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        tick();
        settle();
        $display("[TB] reset values");
        checkOutput("rst_bus", {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o}, 64'd0);
        checkOutput("rst_acks", {i_ack_o, d_ack_o, err_o}, 64'd0);
        checkOutput("rst_rdata", {i_rdata_o, d_rdata_o}, 64'd0);
        tick();
        rst = 1'b0;

        // Single fetch, slave answers in the first bus cycle.
        $display("[TB] single fetch");
        slave_lat  = 0;
        slave_data = 32'h3C011234;
        expectAck(1'b0, 32'h3C011234, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0);
        settle();
        checkOutput("fetch_c0_bus_req", bus_req_o, 0);
        checkOutput("fetch_c0_stall_if", stallreq_if_o, 1);
        tick();
        settle();
        checkOutput("fetch_c1_bus", {bus_req_o, bus_we_o, bus_addr_o}, {1'b1, 1'b0, 32'h100});
        checkOutput("fetch_c1_stall_if", stallreq_if_o, 1);
        tick();
        settle();
        checkOutput("fetch_c2_bus_req", bus_req_o, 0);
        checkOutput("fetch_c2_stall_if", stallreq_if_o, 0);
        tick();
        i_req_i = 1'b0;
        tick();

        // Simultaneous requests with last_grant=I: dbus first, one IDLE gap, then ibus.
        $display("[TB] simultaneous requests");
        slave_data = 32'h0000AAAA;
        expectAck(1'b1, 32'h0000AAAA, 1'b0);
        expectAck(1'b0, 32'h00005555, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h140, 1'b1, 1'b1, 32'h200, 4'hF, 32'hDEADBEEF);
        tick();
        settle();
        checkOutput("tie1_c1_dbus_first", {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o},
                    {1'b1, 1'b1, 4'hF, 32'h200});
        checkOutput("tie1_c1_wdata", bus_wdata_o, 32'hDEADBEEF);
        tick();
        slave_data = 32'h00005555;
        settle();
        checkOutput("tie1_c2_idle_gap", bus_req_o, 0);
        tick();
        d_req_i = 1'b0;
        settle();
        checkOutput("tie1_c3_ibus_second", {bus_req_o, bus_we_o, bus_addr_o}, {1'b1, 1'b0, 32'h140});
        tick();
        tick();
        i_req_i = 1'b0;
        tick();

        // Variable latency dbus read; master changes its address mid-wait.
        $display("[TB] variable latency read");
        slave_lat  = 5;
        slave_data = 32'h0BADF00D;
        expectAck(1'b1, 32'h0BADF00D, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h204, 4'h3, '0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 2) d_addr_i = 32'hFFF0;
            settle();
            checkOutput($sformatf("lat_c%0d_bus_hold", c), {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o},
                        {1'b1, 1'b0, 4'h3, 32'h204});
            checkOutput($sformatf("lat_c%0d_stall_mem", c), stallreq_mem_o, 1);
        end
        tick();
        settle();
        checkOutput("lat_c7_stall_mem", stallreq_mem_o, 0);
        tick();
        d_req_i = 1'b0;
        settle();
        checkOutput("lat_c8_ack_width", d_ack_o, 0);
        tick();

        // Tie with last_grant=D: ibus goes first.
        $display("[TB] tie after dbus");
        slave_lat  = 0;
        slave_data = 32'hCAFE0001;
        expectAck(1'b0, 32'hCAFE0001, 1'b0);
        expectAck(1'b1, 32'hCAFE0002, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h1C0, 1'b1, 1'b1, 32'h208, 4'hF, 32'h12345678);
        tick();
        settle();
        checkOutput("tie2_c1_ibus_first", {bus_req_o, bus_we_o, bus_addr_o}, {1'b1, 1'b0, 32'h1C0});
        tick();
        slave_data = 32'hCAFE0002;
        tick();
        i_req_i = 1'b0;
        settle();
        checkOutput("tie2_c3_dbus_second", {bus_req_o, bus_we_o, bus_addr_o}, {1'b1, 1'b1, 32'h208});
        checkOutput("tie2_c3_wdata", bus_wdata_o, 32'h12345678);
        tick();
        tick();
        d_req_i = 1'b0;
        tick();

        // Flush during the second IBUS cycle: result dropped, refetch served.
        $display("[TB] flush in flight");
        slave_lat  = 2;
        slave_data = 32'h77777777;
        tick();
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, '0, '0, '0);
        tick();
        settle();
        checkOutput("flush_c1_bus", {bus_req_o, bus_addr_o}, {1'b1, 32'h300});
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        i_addr_i   = 32'h180;
        flush_i    = 1'b1;
        slave_lat  = 0;
        slave_data = 32'h24681357;
        settle();
        checkOutput("flush_c4_no_ack", i_ack_o, 0);
        checkOutput("flush_c4_rdata_hold", i_rdata_o, 32'hCAFE0001);
        checkOutput("flush_c4_bus_req", bus_req_o, 0);
        tick();
        flush_i = 1'b0;
        settle();
        checkOutput("flush_idle_blocks_grant", bus_req_o, 0);
        expectAck(1'b0, 32'h24681357, 1'b0);
        tick();
        settle();
        checkOutput("refetch_bus", {bus_req_o, bus_addr_o}, {1'b1, 32'h180});
        tick();
        tick();
        i_req_i = 1'b0;
        tick();

        // Reset in the second DBUS cycle of a write that the slave never acks.
        $display("[TB] reset mid transaction");
        slave_en = 1'b0;
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h400, 4'hF, 32'h99);
        tick();
        settle();
        checkOutput("rstmid_c1_bus_req", bus_req_o, 1);
        tick();
        rst = 1'b1;
        settle();
        checkOutput("rstmid_c2_bus_req", bus_req_o, 1);
        tick();
        rst     = 1'b0;
        d_req_i = 1'b0;
        settle();
        checkOutput("rstmid_bus", {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o}, 64'd0);
        checkOutput("rstmid_wdata", bus_wdata_o, 64'd0);
        checkOutput("rstmid_rdata", {i_rdata_o, d_rdata_o}, 64'd0);
        checkOutput("rstmid_acks", {i_ack_o, d_ack_o, err_o}, 64'd0);
        repeat (3) tick();

`ifdef ARB_TIMEOUT_EN
        // Slave never answers: ack with zero data and err_o in cycle 8.
        $display("[TB] watchdog timeout");
        expectAck(1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, '0, '0, '0);
        for (int c = 1; c <= 7; c++) begin
            tick();
            settle();
            checkOutput($sformatf("wd_c%0d_bus_req", c), bus_req_o, 1);
        end
        tick();
        settle();
        checkOutput("wd_c8_bus_req", bus_req_o, 0);
        checkOutput("wd_c8_err", err_o, 1);
        tick();
        i_req_i = 1'b0;
        settle();
        checkOutput("wd_c9_err", err_o, 0);
        tick();
`endif

        repeat (3) tick();
        settle();
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
